// File: rtl/pim_mem_slave.sv
// pim_mem_slave: memory-side responder for the 32-bit PIM/NPI port, backed by an internal RAM.
// The RAM is zeroed after reset, then single-word, line and burst requests are serviced.
module pim_mem_slave #(
  parameter int unsigned C_AW        = 10,
  parameter int unsigned C_WRFIFO_AW = 6,
  parameter int unsigned C_RDFIFO_AW = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PIM_Addr,
  input  logic        PIM_AddrReq,
  input  logic        PIM_RNW,
  input  logic [3:0]  PIM_Size,
  input  logic        PIM_RdModWr,
  input  logic [31:0] PIM_WrFIFO_Data,
  input  logic [3:0]  PIM_WrFIFO_BE,
  input  logic        PIM_WrFIFO_Push,
  input  logic        PIM_WrFIFO_Flush,
  input  logic        PIM_RdFIFO_Pop,
  input  logic        PIM_RdFIFO_Flush,
  output logic        PIM_AddrAck,
  output logic        PIM_InitDone,
  output logic        PIM_WrFIFO_Empty,
  output logic        PIM_WrFIFO_AlmostFull,
  output logic        PIM_RdFIFO_Empty,
  output logic [31:0] PIM_RdFIFO_Data,
  output logic [3:0]  PIM_RdFIFO_RdWdAddr,
  output logic [1:0]  PIM_RdFIFO_Latency,
  output logic [2:0]  Err
);

  localparam logic [C_WRFIFO_AW:0] WrFull   = {1'b1, {C_WRFIFO_AW{1'b0}}};
  localparam logic [C_WRFIFO_AW:0] WrAfull  = {1'b0, {(C_WRFIFO_AW-1){1'b1}}, 1'b0};
  localparam logic [C_RDFIFO_AW:0] RdFull   = {1'b1, {C_RDFIFO_AW{1'b0}}};
  localparam logic [C_RDFIFO_AW:0] RdRoom1  = {1'b0, {C_RDFIFO_AW{1'b1}}};
  localparam logic [C_AW-1:0]      InitLast = '1;

  typedef enum logic [2:0] {StInit, StIdle, StAck, StWr, StRd} state_e;
  state_e state_q, state_d;

  logic [31:0] ram    [2**C_AW];
  logic [35:0] wr_mem [2**C_WRFIFO_AW];
  logic [35:0] rd_mem [2**C_RDFIFO_AW];

  logic [C_AW-1:0]        init_cnt_q, base_q, mask_q, wa, req_mask, seq_addr, cur_addr;
  logic                   init_done_q, rnw_q, rmw_q, line_q, req_line;
  logic [5:0]             len_q, issue_q, done_q, req_len;
  logic                   rd_pend_q;
  logic [3:0]             rd_off_q, cur_off, rd_wdaddr_q;
  logic [31:0]            ram_rdata_q, rd_data_q;
  logic [2:0]             err_q;
  logic [C_WRFIFO_AW-1:0] wr_wptr_q, wr_rptr_q;
  logic [C_WRFIFO_AW:0]   wr_cnt_q;
  logic [C_RDFIFO_AW-1:0] rd_wptr_q, rd_rptr_q;
  logic [C_RDFIFO_AW:0]   rd_cnt_q;
  logic [35:0]            wr_head;
  logic                   wr_push, wr_pop, rd_room, rd_issue, rd_push, rd_pop;
  logic                   unused_addr;

  assign wa          = PIM_Addr[C_AW+1:2];
  assign unused_addr = ^{PIM_Addr[31:C_AW+2], PIM_Addr[1:0]};

  always_comb begin
    req_len  = 6'd1;
    req_mask = '0;
    req_line = 1'b0;
    case (PIM_Size)
      4'd1: begin req_len = 6'd4;  req_mask = C_AW'(3); req_line = 1'b1; end
      4'd2: begin req_len = 6'd8;  req_mask = C_AW'(7); req_line = 1'b1; end
      4'd3: req_len = 6'd32;
      default: ;
    endcase
  end

  // Line accesses wrap inside the line; writes were aligned at accept time.
  assign seq_addr = base_q + C_AW'(issue_q);
  assign cur_addr = line_q ? ((base_q & ~mask_q) | (seq_addr & mask_q)) : seq_addr;
  assign cur_off  = 4'(seq_addr & mask_q);

  assign wr_head  = wr_mem[wr_rptr_q];
  assign wr_push  = PIM_WrFIFO_Push && !PIM_WrFIFO_Flush && (wr_cnt_q != WrFull);
  assign wr_pop   = (state_q == StWr) && (wr_cnt_q != '0) && !PIM_WrFIFO_Flush;
  // Reserve a slot for the word still in flight from the RAM.
  assign rd_room  = rd_pend_q ? (rd_cnt_q < RdRoom1) : (rd_cnt_q != RdFull);
  assign rd_issue = (state_q == StRd) && (issue_q != len_q) && rd_room && !PIM_RdFIFO_Flush;
  assign rd_push  = rd_pend_q && !PIM_RdFIFO_Flush;
  assign rd_pop   = PIM_RdFIFO_Pop && (rd_cnt_q != '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StInit: if (init_cnt_q == InitLast) state_d = StIdle;
      StIdle: if (PIM_AddrReq) state_d = StAck;
      StAck:  state_d = rnw_q ? StRd : StWr;
      StWr:   if (wr_pop && (issue_q == len_q - 6'd1)) state_d = StIdle;
      StRd:   if (PIM_RdFIFO_Flush || (rd_push && (done_q == len_q - 6'd1))) state_d = StIdle;
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StInit;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      rnw_q       <= 1'b0;
      rmw_q       <= 1'b0;
      line_q      <= 1'b0;
      base_q      <= '0;
      mask_q      <= '0;
      len_q       <= '0;
      issue_q     <= '0;
      done_q      <= '0;
      rd_pend_q   <= 1'b0;
      rd_off_q    <= '0;
      wr_wptr_q   <= '0;
      wr_rptr_q   <= '0;
      wr_cnt_q    <= '0;
      rd_wptr_q   <= '0;
      rd_rptr_q   <= '0;
      rd_cnt_q    <= '0;
      rd_data_q   <= '0;
      rd_wdaddr_q <= '0;
      err_q       <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StInit) begin
        init_cnt_q <= init_cnt_q + 1'b1;
        if (init_cnt_q == InitLast) init_done_q <= 1'b1;
      end
      if ((state_q == StIdle) && PIM_AddrReq) begin
        rnw_q   <= PIM_RNW;
        rmw_q   <= PIM_RdModWr;
        len_q   <= req_len;
        mask_q  <= req_mask;
        line_q  <= req_line;
        base_q  <= (!PIM_RNW && req_line) ? (wa & ~req_mask) : wa;
        issue_q <= '0;
        done_q  <= '0;
        if (PIM_Size > 4'd3) err_q[0] <= 1'b1;
      end
      if (wr_pop || rd_issue) issue_q <= issue_q + 6'd1;
      if (rd_push) done_q <= done_q + 6'd1;
      rd_pend_q <= rd_issue;
      if (rd_issue) rd_off_q <= cur_off;

      if (PIM_WrFIFO_Flush) begin
        wr_wptr_q <= '0;
        wr_rptr_q <= '0;
        wr_cnt_q  <= '0;
      end else begin
        if (wr_push) wr_wptr_q <= wr_wptr_q + 1'b1;
        if (wr_pop)  wr_rptr_q <= wr_rptr_q + 1'b1;
        if (wr_push && !wr_pop)      wr_cnt_q <= wr_cnt_q + 1'b1;
        else if (!wr_push && wr_pop) wr_cnt_q <= wr_cnt_q - 1'b1;
      end
      if (PIM_WrFIFO_Push && !PIM_WrFIFO_Flush && (wr_cnt_q == WrFull)) err_q[1] <= 1'b1;

      if (PIM_RdFIFO_Flush) begin
        rd_wptr_q <= '0;
        rd_rptr_q <= '0;
        rd_cnt_q  <= '0;
      end else begin
        if (rd_push) rd_wptr_q <= rd_wptr_q + 1'b1;
        if (rd_pop)  rd_rptr_q <= rd_rptr_q + 1'b1;
        if (rd_push && !rd_pop)      rd_cnt_q <= rd_cnt_q + 1'b1;
        else if (!rd_push && rd_pop) rd_cnt_q <= rd_cnt_q - 1'b1;
      end
      if (rd_pop) {rd_wdaddr_q, rd_data_q} <= rd_mem[rd_rptr_q];
      if (PIM_RdFIFO_Pop && (rd_cnt_q == '0)) err_q[2] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_push) wr_mem[wr_wptr_q] <= {PIM_WrFIFO_BE, PIM_WrFIFO_Data};
    if (rd_push) rd_mem[rd_wptr_q] <= {rd_off_q, ram_rdata_q};
    if (state_q == StInit) begin
      ram[init_cnt_q] <= '0;
    end else if (wr_pop) begin
      for (int b = 0; b < 4; b++) begin
        if (!rmw_q || wr_head[32+b]) ram[cur_addr][8*b +: 8] <= wr_head[8*b +: 8];
      end
    end
    if (rd_issue) ram_rdata_q <= ram[cur_addr];
  end

  assign PIM_AddrAck           = (state_q == StAck);
  assign PIM_InitDone          = init_done_q;
  assign PIM_WrFIFO_Empty      = (wr_cnt_q == '0);
  assign PIM_WrFIFO_AlmostFull = (wr_cnt_q >= WrAfull);
  assign PIM_RdFIFO_Empty      = (rd_cnt_q == '0);
  assign PIM_RdFIFO_Data       = rd_data_q;
  assign PIM_RdFIFO_RdWdAddr   = rd_wdaddr_q;
  assign PIM_RdFIFO_Latency    = 2'd1;
  assign Err                   = err_q;

endmodule

// File: tb/tb_pim_mem_slave.sv
// tb_pim_mem_slave: table vectors, hand sequences and random traffic for pim_mem_slave,
// checked against a word-array model of the RAM and a queue model of the write FIFO.
module tb_pim_mem_slave;
  localparam int AW    = 4;
  localparam int WORDS = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] PIM_Addr = '0;
  logic        PIM_AddrReq = 1'b0, PIM_RNW = 1'b0, PIM_RdModWr = 1'b0;
  logic [3:0]  PIM_Size = '0, PIM_WrFIFO_BE = '0;
  logic [31:0] PIM_WrFIFO_Data = '0;
  logic        PIM_WrFIFO_Push = 1'b0, PIM_WrFIFO_Flush = 1'b0;
  logic        PIM_RdFIFO_Pop = 1'b0, PIM_RdFIFO_Flush = 1'b0;
  logic        PIM_AddrAck, PIM_InitDone, PIM_WrFIFO_Empty, PIM_WrFIFO_AlmostFull;
  logic        PIM_RdFIFO_Empty;
  logic [31:0] PIM_RdFIFO_Data;
  logic [3:0]  PIM_RdFIFO_RdWdAddr;
  logic [1:0]  PIM_RdFIFO_Latency;
  logic [2:0]  Err;

  pim_mem_slave #(.C_AW(AW), .C_WRFIFO_AW(6), .C_RDFIFO_AW(6)) dut (
    .clk(clk), .rst_n(rst_n), .PIM_Addr(PIM_Addr), .PIM_AddrReq(PIM_AddrReq),
    .PIM_RNW(PIM_RNW), .PIM_Size(PIM_Size), .PIM_RdModWr(PIM_RdModWr),
    .PIM_WrFIFO_Data(PIM_WrFIFO_Data), .PIM_WrFIFO_BE(PIM_WrFIFO_BE),
    .PIM_WrFIFO_Push(PIM_WrFIFO_Push), .PIM_WrFIFO_Flush(PIM_WrFIFO_Flush),
    .PIM_RdFIFO_Pop(PIM_RdFIFO_Pop), .PIM_RdFIFO_Flush(PIM_RdFIFO_Flush),
    .PIM_AddrAck(PIM_AddrAck), .PIM_InitDone(PIM_InitDone),
    .PIM_WrFIFO_Empty(PIM_WrFIFO_Empty), .PIM_WrFIFO_AlmostFull(PIM_WrFIFO_AlmostFull),
    .PIM_RdFIFO_Empty(PIM_RdFIFO_Empty), .PIM_RdFIFO_Data(PIM_RdFIFO_Data),
    .PIM_RdFIFO_RdWdAddr(PIM_RdFIFO_RdWdAddr), .PIM_RdFIFO_Latency(PIM_RdFIFO_Latency),
    .Err(Err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] wr_addr;
    logic [3:0]  wr_size;
    logic        rmw;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] rd_addr;
    logic [31:0] exp;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] mdl_mem [WORDS];
  logic [31:0] wq_data [$];
  logic [3:0]  wq_be   [$];
  logic [31:0] last_pop, last_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int len_of(input logic [3:0] s);
    case (s)
      4'd1: return 4;
      4'd2: return 8;
      4'd3: return 32;
      default: return 1;
    endcase
  endfunction

  function automatic bit is_line(input logic [3:0] s);
    return (s == 4'd1) || (s == 4'd2);
  endfunction

  function automatic int wr_word(input int wa, input logic [3:0] s, input int i);
    int l = len_of(s);
    if (is_line(s)) return (wa - wa % l + i) % WORDS;
    return (wa + i) % WORDS;
  endfunction

  function automatic int rd_word(input int wa, input logic [3:0] s, input int i);
    int l = len_of(s);
    if (is_line(s)) return (wa - wa % l + (wa % l + i) % l) % WORDS;
    return (wa + i) % WORDS;
  endfunction

  function automatic int rd_off(input int wa, input logic [3:0] s, input int i);
    int l = len_of(s);
    if (is_line(s)) return (wa % l + i) % l;
    return 0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [3:0] s, input logic m);
    int wa = int'((a >> 2) % WORDS);
    for (int i = 0; i < len_of(s); i++) begin
      logic [31:0] d = wq_data.pop_front();
      logic [3:0]  b = wq_be.pop_front();
      int          w = wr_word(wa, s, i);
      for (int k = 0; k < 4; k++)
        if (!m || b[k]) mdl_mem[w][8*k +: 8] = d[8*k +: 8];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < WORDS; i++) mdl_mem[i] = '0;
    wq_data.delete();
    wq_be.delete();
  endtask

  task automatic push_word(input logic [31:0] d, input logic [3:0] b);
    PIM_WrFIFO_Push = 1'b1;
    PIM_WrFIFO_Data = d;
    PIM_WrFIFO_BE   = b;
    @(negedge clk);
    PIM_WrFIFO_Push = 1'b0;
    if (wq_data.size() < 64) begin
      wq_data.push_back(d);
      wq_be.push_back(b);
    end
  endtask

  task automatic request(input logic [31:0] a, input logic r, input logic [3:0] s, input logic m);
    bit got = 1'b0;
    PIM_Addr = a; PIM_RNW = r; PIM_Size = s; PIM_RdModWr = m; PIM_AddrReq = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = PIM_AddrAck;
    end
    PIM_AddrReq = 1'b0;
    chk("addr_ack", 32'(got), 32'd1);
  endtask

  task automatic do_write_req(input logic [31:0] a, input logic [3:0] s, input logic m,
                              input logic exp_empty);
    request(a, 1'b0, s, m);
    model_write(a, s, m);
    @(negedge clk);
    chk("ack_pulse", 32'(PIM_AddrAck), 32'd0);
    repeat (len_of(s) + 4) @(negedge clk);
    chk("wr_drained", 32'(PIM_WrFIFO_Empty), 32'(exp_empty));
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] s);
    int n   = len_of(s);
    int wa  = int'((a >> 2) % WORDS);
    int lat = 0;
    request(a, 1'b1, s, 1'b0);
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(negedge clk);
      if (!PIM_RdFIFO_Empty) lat = c;
    end
    chk("rd_latency", 32'(lat), 32'd3);
    repeat (n + 2) @(negedge clk);
    PIM_RdFIFO_Pop = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      last_exp = mdl_mem[rd_word(wa, s, i)];
      chk("rd_data", PIM_RdFIFO_Data, last_exp);
      chk("rd_wdaddr", 32'(PIM_RdFIFO_RdWdAddr), 32'(rd_off(wa, s, i)));
      last_pop = PIM_RdFIFO_Data;
    end
    PIM_RdFIFO_Pop = 1'b0;
    @(negedge clk);
    chk("rd_empty_after", 32'(PIM_RdFIFO_Empty), 32'd1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_ack", 32'(PIM_AddrAck), 32'd0);
    chk("rst_initdone", 32'(PIM_InitDone), 32'd0);
    chk("rst_wr_empty", 32'(PIM_WrFIFO_Empty), 32'd1);
    chk("rst_afull", 32'(PIM_WrFIFO_AlmostFull), 32'd0);
    chk("rst_rd_empty", 32'(PIM_RdFIFO_Empty), 32'd1);
    chk("rst_data", PIM_RdFIFO_Data, 32'd0);
    chk("rst_wdaddr", 32'(PIM_RdFIFO_RdWdAddr), 32'd0);
    chk("rst_latency", 32'(PIM_RdFIFO_Latency), 32'd1);
    chk("rst_err", 32'(Err), 32'd0);
  endtask

  task automatic release_and_init();
    int cnt = 0;
    rst_n = 1'b1;
    while (!PIM_InitDone && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("init_cycles", 32'(cnt), 32'(WORDS));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    tbl[0] = '{32'h10, 4'd0, 1'b1, 4'b0101, 32'hAABBCCDD, 32'h10, 32'h00BB00DD};
    tbl[1] = '{32'h10, 4'd0, 1'b0, 4'b0000, 32'hAABBCCDD, 32'h10, 32'hAABBCCDD};
    tbl[2] = '{32'h14, 4'd0, 1'b1, 4'b1000, 32'h12345678, 32'h14, 32'h12000000};
    tbl[3] = '{32'h14, 4'd0, 1'b1, 4'b0011, 32'h9999ABCD, 32'h14, 32'h1200ABCD};
    tbl[4] = '{32'h57, 4'd0, 1'b0, 4'b0000, 32'hCAFEF00D, 32'h14, 32'hCAFEF00D};
    tbl[5] = '{32'h18, 4'd5, 1'b0, 4'b0000, 32'h5A5A5A5A, 32'h18, 32'h5A5A5A5A};

    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_vals();
    release_and_init();
    do_read(32'h0, 4'd0);
    chk("first_read_zero", last_pop, 32'h0);

    for (int i = 0; i < 6; i++) begin
      push_word(tbl[i].data, tbl[i].be);
      do_write_req(tbl[i].wr_addr, tbl[i].wr_size, tbl[i].rmw, 1'b1);
      do_read(tbl[i].rd_addr, 4'd0);
      chk($sformatf("tbl%0d", i), last_pop, tbl[i].exp);
    end
    chk("err_badsize", 32'(Err[0]), 32'd1);

    // Line write aligns to the line; line read starts at the target word and wraps.
    push_word(32'h11, 4'hF);
    push_word(32'h22, 4'hF);
    push_word(32'h33, 4'hF);
    push_word(32'h44, 4'hF);
    do_write_req(32'h8, 4'd1, 1'b0, 1'b1);
    do_read(32'h4, 4'd1);
    chk("line_last", last_pop, 32'h11);

    // Push and flush together: flush wins.
    PIM_WrFIFO_Push = 1'b1; PIM_WrFIFO_Flush = 1'b1; PIM_WrFIFO_Data = 32'hDEAD;
    @(negedge clk);
    PIM_WrFIFO_Push = 1'b0; PIM_WrFIFO_Flush = 1'b0;
    chk("push_flush_empty", 32'(PIM_WrFIFO_Empty), 32'd1);

    // Overflow: 66 pushes into a 64-deep FIFO.
    for (int i = 1; i <= 66; i++) begin
      push_word($urandom, 4'hF);
      if (i == 61) chk("afull_61", 32'(PIM_WrFIFO_AlmostFull), 32'd0);
      if (i == 62) chk("afull_62", 32'(PIM_WrFIFO_AlmostFull), 32'd1);
      if (i == 64) chk("err1_at_64", 32'(Err[1]), 32'd0);
    end
    chk("err1_overflow", 32'(Err[1]), 32'd1);
    do_write_req(32'h0, 4'd3, 1'b0, 1'b0);
    do_write_req(32'h0, 4'd3, 1'b0, 1'b1);
    do_read(32'h0, 4'd3);

    // Underflow: data holds, Err[2] sets.
    chk("err2_clear", 32'(Err[2]), 32'd0);
    PIM_RdFIFO_Pop = 1'b1;
    @(negedge clk);
    PIM_RdFIFO_Pop = 1'b0;
    chk("underflow_hold", PIM_RdFIFO_Data, last_exp);
    chk("err2_underflow", 32'(Err[2]), 32'd1);

    // Flush in the middle of a burst read.
    request(32'h0, 1'b1, 4'd3, 1'b0);
    repeat (8) @(negedge clk);
    PIM_RdFIFO_Pop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("flush_pre_data", PIM_RdFIFO_Data, mdl_mem[rd_word(0, 4'd3, i)]);
    end
    PIM_RdFIFO_Pop = 1'b0;
    PIM_RdFIFO_Flush = 1'b1;
    @(negedge clk);
    PIM_RdFIFO_Flush = 1'b0;
    chk("flush_empty", 32'(PIM_RdFIFO_Empty), 32'd1);
    repeat (3) @(negedge clk);
    chk("flush_no_stale", 32'(PIM_RdFIFO_Empty), 32'd1);
    do_read(32'h1C, 4'd0);

    // Random write/read traffic.
    for (int it = 0; it < 25; it++) begin
      logic [3:0]  s  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15))
                                                    : 4'($urandom_range(0, 3));
      logic [31:0] a  = $urandom;
      logic        m  = 1'($urandom);
      logic [3:0]  rs = 4'($urandom_range(0, 3));
      for (int i = 0; i < len_of(s); i++) push_word($urandom, 4'($urandom));
      do_write_req(a, s, m, 1'b1);
      do_read($urandom, rs);
    end

    // Reset during a burst write.
    for (int i = 0; i < 32; i++) push_word($urandom | 32'h1, 4'hF);
    request(32'h20, 1'b0, 4'd3, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    model_reset();
    @(negedge clk);
    release_and_init();
    do_read(32'h0, 4'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
